// File: rtl/accum16_seq_if.sv
// Stream bundle for accum16_seq: job request, operand input stream and result output stream.
// slave is the accumulator's view; master is the view of whoever drives jobs and consumes results.
interface accum16_seq_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] count;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_sum;
    logic             out_sign;
    logic             out_zero;
    logic             out_parity;
    logic             out_carry;
    logic             out_overflow;
    logic             busy;

    modport slave (
        input  start, count, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_sign, out_zero, out_parity,
               out_carry, out_overflow, busy
    );

    modport master (
        output start, count, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_sign, out_zero, out_parity,
               out_carry, out_overflow, busy
    );
endinterface

// File: rtl/accum16_seq.sv
// Sequential multi-operand 16-bit accumulator with sticky carry/overflow and a valid/ready result port.
// Optional feature macro ACCUM_SAT_EN: saturate the accumulator on signed overflow instead of wrapping.
module accum16_seq #(
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    accum16_seq_if.slave  io_bus,
    output logic [1:0]    o_dbg_state
);
    // Handshake: a transfer happens on a rising edge where valid & ready are both 1;
    // valid never waits on ready, and ready is a pure decode of the FSM state.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [15:0]      r_acc;
    logic [CNT_W-1:0] r_remaining;
    logic             r_carry;
    logic             r_ovf;

    logic             w_beat;
    logic             w_job_clear;
    logic [16:0]      w_add;
    logic [15:0]      w_acc_nxt;
    logic             w_step_ovf;
    logic             w_show_flags;

    // Adder step: bit 16 of the widened sum is the unsigned carry-out.
    assign w_add      = {1'b0, r_acc} + {1'b0, io_bus.in_data};
    assign w_step_ovf = (r_acc[15] & io_bus.in_data[15] & ~w_add[15]) |
                        (~r_acc[15] & ~io_bus.in_data[15] & w_add[15]);

`ifdef ACCUM_SAT_EN
    always_comb begin
        w_acc_nxt = w_add[15:0];
        if (w_step_ovf) begin
            w_acc_nxt = r_acc[15] ? 16'h8000 : 16'h7FFF;
        end
    end
`else
    assign w_acc_nxt = w_add[15:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_beat           = 1'b0;
        w_job_clear      = 1'b0;
        io_bus.in_ready  = 1'b0;
        io_bus.out_valid = 1'b0;
        io_bus.busy      = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (io_bus.start) begin
                    w_job_clear = 1'b1;
                    w_state_nxt = (io_bus.count != CNT_ZERO) ? S_ACC : S_DONE;
                end
            end
            S_ACC: begin
                io_bus.in_ready = 1'b1;
                w_beat          = io_bus.in_valid;
                if (w_beat && (r_remaining == CNT_ONE)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                io_bus.out_valid = 1'b1;
                if (io_bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // A zero-length job loads remaining=0 but goes straight to DONE, so it never decrements.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= 16'h0000;
            r_remaining <= CNT_ZERO;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_job_clear) begin
            r_acc       <= 16'h0000;
            r_remaining <= io_bus.count;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_beat) begin
            r_acc       <= w_acc_nxt;
            r_remaining <= r_remaining - CNT_ONE;
            r_carry     <= r_carry | w_add[16];
            r_ovf       <= r_ovf | w_step_ovf;
        end
    end

    // Value decodes are held at 0 in IDLE so that every output reads 0 out of reset.
    assign w_show_flags = (r_state != S_IDLE);

    assign io_bus.out_sum      = r_acc;
    assign io_bus.out_sign     = w_show_flags & r_acc[15];
    assign io_bus.out_zero     = w_show_flags & ~(|r_acc);
    assign io_bus.out_parity   = w_show_flags & ~(^r_acc);
    assign io_bus.out_carry    = r_carry;
    assign io_bus.out_overflow = r_ovf;
    assign o_dbg_state         = r_state;
endmodule

// File: tb/tb_accum16_seq.sv
// Directed bench for accum16_seq: hand-computed jobs checked with immediate assertions.
// Expected sums are queued per job and popped when the result is presented.
module tb_accum16_seq;
    localparam int CNT_W = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  dbg_state;
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];

    accum16_seq_if #(.CNT_W(CNT_W)) bus_if ();

    accum16_seq #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .io_bus      (bus_if.slave),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".in_ready"},  {31'd0, bus_if.in_ready},     32'd0);
        chk({tag, ".out_valid"}, {31'd0, bus_if.out_valid},    32'd0);
        chk({tag, ".busy"},      {31'd0, bus_if.busy},         32'd0);
        chk({tag, ".sum"},       {16'd0, bus_if.out_sum},      32'd0);
        chk({tag, ".sign"},      {31'd0, bus_if.out_sign},     32'd0);
        chk({tag, ".zero"},      {31'd0, bus_if.out_zero},     32'd0);
        chk({tag, ".parity"},    {31'd0, bus_if.out_parity},   32'd0);
        chk({tag, ".carry"},     {31'd0, bus_if.out_carry},    32'd0);
        chk({tag, ".ovf"},       {31'd0, bus_if.out_overflow}, 32'd0);
        chk({tag, ".state"},     {30'd0, dbg_state},           32'd0);
    endtask

    task automatic start_job(input logic [CNT_W-1:0] cnt);
        bus_if.start = 1'b1;
        bus_if.count = cnt;
        @(negedge clk);
        bus_if.start = 1'b0;
        bus_if.count = '0;
    endtask

    task automatic send_beat(input logic [15:0] data, input int gap);
        int k;
        bus_if.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = data;
        k = 0;
        while (!bus_if.in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("in_ready_wait", {31'd0, bus_if.in_ready}, 32'd1);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        bus_if.in_data  = 16'hDEAD;
    endtask

    task automatic check_result(input string tag, input logic sign, input logic zero,
                                input logic parity, input logic carry, input logic ovf);
        logic [15:0] exp_sum;
        exp_sum = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hXXXX;
        chk({tag, ".out_valid"}, {31'd0, bus_if.out_valid},    32'd1);
        chk({tag, ".sum"},       {16'd0, bus_if.out_sum},      {16'd0, exp_sum});
        chk({tag, ".sign"},      {31'd0, bus_if.out_sign},     {31'd0, sign});
        chk({tag, ".zero"},      {31'd0, bus_if.out_zero},     {31'd0, zero});
        chk({tag, ".parity"},    {31'd0, bus_if.out_parity},   {31'd0, parity});
        chk({tag, ".carry"},     {31'd0, bus_if.out_carry},    {31'd0, carry});
        chk({tag, ".ovf"},       {31'd0, bus_if.out_overflow}, {31'd0, ovf});
    endtask

    task automatic accept_result(input string tag);
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        bus_if.out_ready = 1'b0;
        chk({tag, ".idle_busy"},  {31'd0, bus_if.busy},      32'd0);
        chk({tag, ".idle_state"}, {30'd0, dbg_state},        32'd0);
        chk({tag, ".idle_valid"}, {31'd0, bus_if.out_valid}, 32'd0);
    endtask

    initial begin
        bus_if.start     = 1'b0;
        bus_if.count     = '0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_data   = 16'h0000;
        bus_if.out_ready = 1'b0;

        // Reset state
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");

        // Job 1: 0x0001 + 0x0002
        exp_q.push_back(16'h0003);
        start_job(8'd2);
        chk("j1.in_ready_latency", {31'd0, bus_if.in_ready}, 32'd1);
        chk("j1.busy",             {31'd0, bus_if.busy},     32'd1);
        send_beat(16'h0001, 0);
        chk("j1.acc_mid", {16'd0, bus_if.out_sum}, 32'h0001);
        send_beat(16'h0002, 0);
        check_result("j1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        accept_result("j1");

        // Job 2: 0xFFFF + 0x0001 wraps to zero with carry
        exp_q.push_back(16'h0000);
        start_job(8'd2);
        send_beat(16'hFFFF, 0);
        send_beat(16'h0001, 0);
        check_result("j2", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        accept_result("j2");

        // Job 3: positive signed overflow
        start_job(8'd2);
        send_beat(16'h7FFF, 0);
        send_beat(16'h0001, 0);
`ifdef ACCUM_SAT_EN
        exp_q.push_back(16'h7FFF);
        check_result("j3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`else
        exp_q.push_back(16'h8000);
        check_result("j3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
        accept_result("j3");

        // Job 4: negative signed overflow 0x8000 + 0x8000
        start_job(8'd2);
        send_beat(16'h8000, 0);
        send_beat(16'h8000, 0);
`ifdef ACCUM_SAT_EN
        exp_q.push_back(16'h8000);
        check_result("j4", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
`else
        exp_q.push_back(16'h0000);
        check_result("j4", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
`endif
        accept_result("j4");

        // Job 5: zero-length job goes straight to DONE
        exp_q.push_back(16'h0000);
        start_job(8'd0);
        chk("j5.in_ready", {31'd0, bus_if.in_ready}, 32'd0);
        check_result("j5", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        accept_result("j5");

        // Job 6: gapped beats, held result, start during DONE ignored
        exp_q.push_back(16'h0200);
        start_job(8'd3);
        send_beat(16'h0100, 3);
        send_beat(16'h0200, 3);
        chk("j6.gap_busy", {31'd0, bus_if.busy}, 32'd1);
        send_beat(16'hFF00, 3);
        for (int c = 0; c < 5; c++) begin
            bus_if.start = (c == 2);
            bus_if.count = (c == 2) ? 8'd5 : 8'd0;
            chk("j6.hold_valid", {31'd0, bus_if.out_valid}, 32'd1);
            chk("j6.hold_sum",   {16'd0, bus_if.out_sum},   32'h0200);
            chk("j6.hold_carry", {31'd0, bus_if.out_carry}, 32'd1);
            @(negedge clk);
        end
        bus_if.start = 1'b0;
        bus_if.count = '0;
        check_result("j6", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        accept_result("j6");
        @(negedge clk);
        chk("j6.start_ignored", {31'd0, bus_if.busy}, 32'd0);

        // Job 7: reset after the first of three beats, then a fresh job
        start_job(8'd3);
        send_beat(16'h1111, 0);
        chk("j7.acc_mid", {16'd0, bus_if.out_sum}, 32'h1111);
        rst = 1'b1;
        #1;
        check_all_zero("j7.rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_q.push_back(16'h1234);
        start_job(8'd1);
        send_beat(16'h1234, 0);
        check_result("j7", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        accept_result("j7");

        // Job 8: maximum job length, 255 x 0x0001
        exp_q.push_back(16'h00FF);
        start_job(8'd255);
        for (int b = 0; b < 255; b++) begin
            send_beat(16'h0001, 0);
        end
        check_result("j8", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        accept_result("j8");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
